// File: rtl/dffe_arb_pkg.sv
// Shared types, default sizes and index helper for the DFFE bank arbiter.
package dffe_arb_pkg;

    // IDLE picks a winner, WRITE pulses the bank enable, ACK pulses the requester's ack.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } arb_state_t;

    localparam int N_REQ_DEF     = 4;
    localparam int WIDTH_DEF     = 8;
    localparam int CNT_WIDTH_DEF = 16;

    // Next requester index, wrapping from n-1 back to 0.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_select
    import dffe_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     valid,
    output logic [$clog2(N_REQ)-1:0] index
);

    localparam int IDX_W = $clog2(N_REQ);

    int unsigned cand;

    // Walk the candidates starting at ptr; the first one with req set wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 32'(ptr);
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!valid && (32'(j) == cand) && req[j]) begin
                    valid = 1'b1;
                    index = IDX_W'(j);
                end
            end
            cand = next_idx(cand, 32'(N_REQ));
        end
    end

endmodule

// File: rtl/dffe_bank_arbiter.sv
// Round-robin write arbiter driving the shared D bus and enable of one DFFE bank.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting; on any req, latch winner's data and grant_id
//   WRITE | reg_enable high for this one cycle, bank captures at its end
//   ACK   | ack[grant_id] high; on exit count the write, advance pointer
module dffe_bank_arbiter
    import dffe_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                     clock,
    input  logic                     n_reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH-1:0]         reg_d,
    output logic                     reg_enable,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     write_count
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_valid;
    logic [WIDTH-1:0] wdata_sel;
    logic [N_REQ-1:0] ack_onehot;

    rr_select #(
        .N_REQ (N_REQ)
    ) u_rr_select (
        .req   (req),
        .ptr   (ptr),
        .valid (sel_valid),
        .index (sel_idx)
    );

    // State register.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a grant always runs the full WRITE/ACK sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_valid) state_nxt = WRITE;
            WRITE:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Winner's data slice, ack pattern for the granted index and the post-grant pointer.
    always_comb begin
        wdata_sel  = '0;
        ack_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx == IDX_W'(i)) wdata_sel = wdata[i*WIDTH +: WIDTH];
            ack_onehot[i] = (grant_id == IDX_W'(i));
        end
        ptr_nxt = IDX_W'(next_idx(32'(grant_id), 32'(N_REQ)));
    end

    // Registered outputs; reg_d and grant_id only change on a new grant.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            ack         <= '0;
            reg_d       <= '0;
            reg_enable  <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            write_count <= '0;
            ptr         <= '0;
        end else begin
            ack        <= '0;
            reg_enable <= 1'b0;
            busy       <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        reg_d      <= wdata_sel;
                        grant_id   <= sel_idx;
                        reg_enable <= 1'b1;
                    end
                end
                WRITE: begin
                    ack <= ack_onehot;
                end
                ACK: begin
                    write_count <= write_count + CNT_WIDTH'(1);
                    ptr         <= ptr_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dffe_bank_arbiter.sv
// Self-checking bench for dffe_bank_arbiter with a DFFE bank on its outputs.
module tb_dffe_bank_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;

    logic           clock   = 1'b0;
    logic           n_reset = 1'b0;
    logic [N-1:0]   req     = '0;
    logic [N*W-1:0] wdata   = '0;
    logic [N-1:0]   ack;
    logic [W-1:0]   reg_d;
    logic           reg_enable;
    logic [1:0]     grant_id;
    logic           busy;
    logic [CW-1:0]  write_count;
    logic [W-1:0]   bank_q  = '0;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: where a write is in its 3-cycle life, who owns it.
    int           m_ptr   = 0;
    int           m_cnt   = 0;
    int           m_phase = 0;
    int           m_g     = 0;
    logic [W-1:0] m_d     = '0;
    logic [W-1:0] m_bank  = '0;

    dffe_bank_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .CNT_WIDTH (CW)
    ) dut (
        .clock       (clock),
        .n_reset     (n_reset),
        .req         (req),
        .wdata       (wdata),
        .ack         (ack),
        .reg_d       (reg_d),
        .reg_enable  (reg_enable),
        .grant_id    (grant_id),
        .busy        (busy),
        .write_count (write_count)
    );

    always #5 clock = ~clock;

    // W enable-gated D flip-flops forming the bank.
    always @(posedge clock) begin
        for (int b = 0; b < W; b++) begin
            if (reg_enable) bank_q[b] <= reg_d[b];
        end
    end

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_phase = 0; m_g = 0; m_d = '0;
    endtask

    task automatic model_step();
        if (m_phase == 0) begin
            if (req != '0) begin
                m_g     = pick(req, m_ptr);
                m_d     = wdata[m_g*W +: W];
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_bank  = m_d;
            m_phase = 2;
        end else begin
            m_cnt   = (m_cnt + 1) % (1 << CW);
            m_ptr   = (m_g + 1) % N;
            m_phase = 0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (n_reset) model_step();
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++; if (ack !== '0)         begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
        checks++; if (reg_d !== '0)       begin errors++; $display("FAIL reset_reg_d got %h want 0", reg_d); end
        checks++; if (reg_enable !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", reg_enable); end
        checks++; if (grant_id !== '0)    begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (write_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", write_count); end
        @(negedge clock);
        n_reset = 1'b1;
        repeat (3) tick();
        checks++; if (reg_enable !== 1'b0 || busy !== 1'b0 || ack !== '0)
            begin errors++; $display("FAIL idle_noreq got en=%b busy=%b ack=%b want 0", reg_enable, busy, ack); end
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 0; i < N; i++) wdata[i*W +: W] = W'($urandom);
        wdata[2*W +: W] = 8'hA5;
        req = 4'b0100;
        tick();
        checks++; if (reg_enable !== 1'b1) begin errors++; $display("FAIL single_en got %b want 1", reg_enable); end
        checks++; if (grant_id !== 2'd2)   begin errors++; $display("FAIL single_grant got %0d want 2", grant_id); end
        checks++; if (ack !== '0)          begin errors++; $display("FAIL single_early_ack got %b want 0", ack); end
        tick();
        checks++; if (bank_q !== 8'hA5)    begin errors++; $display("FAIL single_bank got %h want a5", bank_q); end
        checks++; if (ack !== 4'b0100)     begin errors++; $display("FAIL single_ack got %b want 0100", ack); end
        checks++; if (reg_enable !== 1'b0) begin errors++; $display("FAIL single_en_off got %b want 0", reg_enable); end
        req = '0;
        tick();
        checks++; if (write_count !== 2'd1) begin errors++; $display("FAIL single_count got %0d want 1", write_count); end
        checks++; if (busy !== 1'b0 || ack !== '0) begin errors++; $display("FAIL single_done got busy=%b ack=%b want 0", busy, ack); end
        checks++; if (reg_d !== 8'hA5)     begin errors++; $display("FAIL single_hold got %h want a5", reg_d); end
    endtask

    task automatic test_contention();
        int acks[$];
        int ack_t[$];
        int exp_ord[5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) wdata[i*W +: W] = W'(8'h11 * (i + 1));
        req = 4'b1111;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (ack != '0) begin
                int idx = -1;
                for (int i = 0; i < N; i++) if (ack[i]) idx = i;
                acks.push_back(idx);
                ack_t.push_back(c);
                checks++;
                if (bank_q !== W'(8'h11 * (idx + 1)))
                    begin errors++; $display("FAIL cont_bank got %h want %h", bank_q, W'(8'h11 * (idx + 1))); end
            end
        end
        req = '0;
        checks++;
        if (acks.size() != 5) begin
            errors++; $display("FAIL cont_num_acks got %0d want 5", acks.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (acks[k] != exp_ord[k]) begin errors++; $display("FAIL cont_order[%0d] got %0d want %0d", k, acks[k], exp_ord[k]); end
                if (k > 0) begin
                    checks++;
                    if (ack_t[k] - ack_t[k-1] != 3)
                        begin errors++; $display("FAIL cont_spacing[%0d] got %0d want 3", k, ack_t[k] - ack_t[k-1]); end
                end
            end
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < N; i++) wdata[i*W +: W] = W'($urandom);
        req = 4'b0100;
        tick(); req = '0; tick(); tick();
        req = 4'b1001;
        tick();
        checks++; if (grant_id !== 2'd3 || reg_enable !== 1'b1)
            begin errors++; $display("FAIL wrap_first got grant=%0d en=%b want 3/1", grant_id, reg_enable); end
        tick();
        checks++; if (ack !== 4'b1000) begin errors++; $display("FAIL wrap_ack3 got %b want 1000", ack); end
        req = 4'b0001;
        tick(); tick();
        checks++; if (grant_id !== 2'd0 || reg_enable !== 1'b1)
            begin errors++; $display("FAIL wrap_second got grant=%0d en=%b want 0/1", grant_id, reg_enable); end
        tick();
        checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wrap_ack0 got %b want 0001", ack); end
        req = '0;
        tick();
    endtask

    task automatic test_withdrawal();
        do_reset();
        wdata[1*W +: W] = 8'h3C;
        req = 4'b0010;
        tick();
        req = '0;
        tick();
        checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL wd_ack got %b want 0010", ack); end
        checks++; if (bank_q !== 8'h3C) begin errors++; $display("FAIL wd_bank got %h want 3c", bank_q); end
        tick();
        checks++; if (write_count !== 2'd1) begin errors++; $display("FAIL wd_count got %0d want 1", write_count); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++; if (reg_enable !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL wd_regrant got en=%b busy=%b want 0", reg_enable, busy); end
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        wdata[1*W +: W] = 8'h5A;
        req = 4'b0010;
        tick(); req = '0; tick(); tick();
        checks++; if (bank_q !== 8'h5A) begin errors++; $display("FAIL rmw_pre_bank got %h want 5a", bank_q); end
        wdata[1*W +: W] = 8'hC3;
        wdata[2*W +: W] = 8'h96;
        req = 4'b0110;
        tick();
        checks++; if (grant_id !== 2'd2 || reg_enable !== 1'b1)
            begin errors++; $display("FAIL rmw_grant got grant=%0d en=%b want 2/1", grant_id, reg_enable); end
        n_reset = 1'b0;
        model_reset();
        #1;
        checks++; if (reg_enable !== 1'b0) begin errors++; $display("FAIL rmw_en got %b want 0", reg_enable); end
        checks++; if (busy !== 1'b0 || ack !== '0) begin errors++; $display("FAIL rmw_busy got busy=%b ack=%b want 0", busy, ack); end
        checks++; if (grant_id !== '0 || write_count !== '0)
            begin errors++; $display("FAIL rmw_regs got grant=%0d cnt=%0d want 0", grant_id, write_count); end
        tick(); tick();
        checks++; if (bank_q !== 8'h5A) begin errors++; $display("FAIL rmw_bank got %h want 5a", bank_q); end
        @(negedge clock);
        n_reset = 1'b1;
        tick();
        checks++; if (grant_id !== 2'd1 || reg_d !== 8'hC3)
            begin errors++; $display("FAIL rmw_restart got grant=%0d d=%h want 1/c3", grant_id, reg_d); end
        req = 4'b0100;
        tick();
        checks++; if (bank_q !== 8'hC3) begin errors++; $display("FAIL rmw_post_bank got %h want c3", bank_q); end
        req = '0;
        tick();
    endtask

    task automatic test_counter_wrap();
        int exp_cnt[5] = '{1, 2, 3, 0, 1};
        do_reset();
        for (int w = 0; w < 5; w++) begin
            wdata = {$urandom, $urandom};
            req = N'(1) << $urandom_range(N - 1, 0);
            tick(); req = '0; tick(); tick();
            checks++;
            if (write_count !== CW'(exp_cnt[w]))
                begin errors++; $display("FAIL cnt_wrap[%0d] got %0d want %0d", w, write_count, exp_cnt[w]); end
        end
    endtask

    task automatic test_random();
        logic         prev_en;
        logic [N-1:0] exp_ack;
        prev_en = 1'b0;
        req = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_phase == 2 && m_g == i) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    wdata[i*W +: W] = W'($urandom);
                end else if (!req[i] && $urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                    wdata[i*W +: W] = W'($urandom);
                end
            end
            tick();
            exp_ack = (m_phase == 2) ? (N'(1) << m_g) : '0;
            checks++; if (reg_enable !== (m_phase == 1))
                begin errors++; $display("FAIL rand_en c%0d got %b want %b", c, reg_enable, m_phase == 1); end
            checks++; if (busy !== (m_phase != 0))
                begin errors++; $display("FAIL rand_busy c%0d got %b want %b", c, busy, m_phase != 0); end
            checks++; if (ack !== exp_ack)
                begin errors++; $display("FAIL rand_ack c%0d got %b want %b", c, ack, exp_ack); end
            checks++; if (grant_id !== 2'(m_g))
                begin errors++; $display("FAIL rand_grant c%0d got %0d want %0d", c, grant_id, m_g); end
            checks++; if (reg_d !== m_d)
                begin errors++; $display("FAIL rand_d c%0d got %h want %h", c, reg_d, m_d); end
            checks++; if (write_count !== CW'(m_cnt))
                begin errors++; $display("FAIL rand_count c%0d got %0d want %0d", c, write_count, m_cnt); end
            checks++; if (bank_q !== m_bank)
                begin errors++; $display("FAIL rand_bank c%0d got %h want %h", c, bank_q, m_bank); end
            checks++; if (prev_en && reg_enable)
                begin errors++; $display("FAIL rand_en_twice c%0d got 1 want 0", c); end
            prev_en = reg_enable;
        end
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_withdrawal();
        test_reset_mid_write();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
